count_display_driver: RTL and testbench

//  Downstream consumer of the 4-bit up counter: latches the count on a load strobe and

---
 rtl/seg7_pkg.sv | 22 ++
 rtl/seg7_hex_decode.sv | 13 +
 rtl/count_display_driver.sv | 108 ++++++++++
 tb/tb_count_display_driver.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared 7-segment definitions: active-low segment table, slot encodings and anode idle value.
package seg7_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [3:0] AN_OFF    = 4'b1111;

    typedef enum logic [1:0] {
        DIG0 = 2'd0,
        DIG1 = 2'd1,
        DIG2 = 2'd2,
        DIG3 = 2'd3
    } slot_t;

    // Packed table indexed by nibble; entry 15 is leftmost, entry 0 rightmost. Bit order {g,f,e,d,c,b,a}.
    localparam logic [15:0][6:0] HEX_SEG = {
        7'b0001110, 7'b0000110, 7'b0100001, 7'b1000110,
        7'b0000011, 7'b0001000, 7'b0010000, 7'b0000000,
        7'b1111000, 7'b0000010, 7'b0010010, 7'b0011001,
        7'b0110000, 7'b0100100, 7'b1111001, 7'b1000000
    };

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational nibble to active-low 7-segment pattern, hex 0-F.
module seg7_hex_decode
    import seg7_pkg::*;
(
    input  logic [3:0] i_hex,
    output logic [6:0] o_seg
);

    always_comb begin
        o_seg = HEX_SEG[i_hex];
    end

endmodule

// File: rtl/count_display_driver.sv
// Latches a 4-bit count, tracks 15->0 wraps, and scans it onto a 4-digit common-anode display.
module count_display_driver
    import seg7_pkg::*;
#(
    parameter int unsigned REFRESH_DIV  = 100000,
    parameter int unsigned BLANK_CYCLES = 64,
    parameter bit          BLANK_LZ     = 1'b1
) (
    input  logic       clk,
    input  logic       Clear_n,
    input  logic [3:0] count,
    input  logic       count_load,
    output logic [6:0] seg,
    output logic [3:0] an,
    output logic       dp
);

    localparam int unsigned PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [PW-1:0] PRE_LAST  = PW'(REFRESH_DIV - 1);
    localparam logic [PW-1:0] PRE_BLANK = PW'(BLANK_CYCLES);

    logic [3:0]    r_value;
    logic [3:0]    r_wrap;
    logic [PW-1:0] r_pre;
    slot_t         r_slot;

    logic       w_ge10;
    logic [3:0] w_units;
    logic [3:0] w_tens;
    logic [3:0] w_nib;
    logic [6:0] w_dec;
    logic [6:0] w_seg_next;
    logic [3:0] w_an_next;
    logic       w_dp_next;

    // Values are 0..15, so tens is 0 or 1 and a single compare replaces a divider.
    always_comb begin
        w_ge10  = (r_value >= 4'd10);
        w_units = w_ge10 ? (r_value - 4'd10) : r_value;
        w_tens  = {3'b000, w_ge10};
        case (r_slot)
            DIG1:    w_nib = w_tens;
            DIG3:    w_nib = r_wrap;
            default: w_nib = w_units;
        endcase
    end

    seg7_hex_decode u_decode (
        .i_hex (w_nib),
        .o_seg (w_dec)
    );

    always_comb begin
        w_seg_next = SEG_BLANK;
        w_an_next  = AN_OFF;
        w_dp_next  = 1'b1;
        if (r_pre >= PRE_BLANK) begin
            case (r_slot)
                DIG0: begin
                    w_an_next  = 4'b1110;
                    w_seg_next = w_dec;
                end
                DIG1: begin
                    w_an_next  = 4'b1101;
                    w_seg_next = (BLANK_LZ && !w_ge10) ? SEG_BLANK : w_dec;
                end
                DIG2: begin
                    w_an_next  = 4'b1011;
                    w_seg_next = SEG_BLANK;
                end
                default: begin
                    w_an_next  = 4'b0111;
                    w_seg_next = w_dec;
                    w_dp_next  = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge Clear_n) begin
        if (!Clear_n) begin
            r_value <= '0;
            r_wrap  <= '0;
            r_pre   <= '0;
            r_slot  <= DIG0;
            seg     <= SEG_BLANK;
            an      <= AN_OFF;
            dp      <= 1'b1;
        end else begin
            if (count_load) begin
                r_value <= count;
                if (r_value == 4'hF && count == 4'h0) begin
                    r_wrap <= r_wrap + 4'd1;
                end
            end
            if (r_pre == PRE_LAST) begin
                r_pre  <= '0;
                r_slot <= slot_t'(r_slot + 2'd1);
            end else begin
                r_pre <= r_pre + 1'b1;
            end
            seg <= w_seg_next;
            an  <= w_an_next;
            dp  <= w_dp_next;
        end
    end

endmodule

// File: tb/tb_count_display_driver.sv
// Randomized and directed bench for count_display_driver against a cycle-level behavioural model.
module tb_count_display_driver;

    localparam int R = 8;
    localparam int B = 2;

    logic       clk = 1'b0;
    logic       Clear_n = 1'b1;
    logic [3:0] count = 4'd0;
    logic       count_load = 1'b0;
    logic [6:0] seg_a, seg_b;
    logic [3:0] an_a, an_b;
    logic       dp_a, dp_b;

    int checks = 0;
    int failures = 0;

    count_display_driver #(.REFRESH_DIV(R), .BLANK_CYCLES(B), .BLANK_LZ(1'b1)) u_dut_lz (
        .clk(clk), .Clear_n(Clear_n), .count(count), .count_load(count_load),
        .seg(seg_a), .an(an_a), .dp(dp_a)
    );

    count_display_driver #(.REFRESH_DIV(R), .BLANK_CYCLES(B), .BLANK_LZ(1'b0)) u_dut_nlz (
        .clk(clk), .Clear_n(Clear_n), .count(count), .count_load(count_load),
        .seg(seg_b), .an(an_b), .dp(dp_b)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] hex7(input int v);
        case (v)
            0: return 7'b1000000;   1: return 7'b1111001;   2: return 7'b0100100;   3: return 7'b0110000;
            4: return 7'b0011001;   5: return 7'b0010010;   6: return 7'b0000010;   7: return 7'b1111000;
            8: return 7'b0000000;   9: return 7'b0010000;  10: return 7'b0001000;  11: return 7'b0000011;
           12: return 7'b1000110;  13: return 7'b0100001;  14: return 7'b0000110;  default: return 7'b0001110;
        endcase
    endfunction

    // Outputs after an edge reflect the phase and slot seen just before it: {seg, an, dp}.
    function automatic logic [11:0] expect_out(input int p, input int s, input int v, input int w, input bit lz);
        logic [6:0] sg;
        logic [3:0] a;
        logic       d;
        if (p < B) return {7'h7F, 4'hF, 1'b1};
        a = 4'hF;
        a[s] = 1'b0;
        d = 1'b1;
        case (s)
            0: sg = hex7(v % 10);
            1: sg = (lz && v < 10) ? 7'h7F : hex7(v / 10);
            2: sg = 7'h7F;
            default: begin sg = hex7(w); d = 1'b0; end
        endcase
        return {sg, a, d};
    endfunction

    int m_n = 0;
    int m_val = 0;
    int m_wrap = 0;
    logic [11:0] e_a = {7'h7F, 4'hF, 1'b1};
    logic [11:0] e_b = {7'h7F, 4'hF, 1'b1};

    always @(posedge clk or negedge Clear_n) begin
        if (!Clear_n) begin
            m_n = 0; m_val = 0; m_wrap = 0;
            e_a = {7'h7F, 4'hF, 1'b1};
            e_b = {7'h7F, 4'hF, 1'b1};
        end else begin
            e_a = expect_out(m_n % R, (m_n / R) % 4, m_val, m_wrap, 1'b1);
            e_b = expect_out(m_n % R, (m_n / R) % 4, m_val, m_wrap, 1'b0);
            if (count_load) begin
                if (m_val == 15 && count == 4'd0) m_wrap = (m_wrap + 1) % 16;
                m_val = count;
            end
            m_n = m_n + 1;
        end
    end

    task automatic chk(input string nm, input logic [11:0] got, input logic [11:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h at %0t", nm, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("scan_lz", {seg_a, an_a, dp_a}, e_a);
        chk("scan_nlz", {seg_b, an_b, dp_b}, e_b);
    end

    task automatic wait_an(input logic [3:0] want);
        int n = 0;
        @(negedge clk);
        while (an_a !== want && n < 80) begin
            @(negedge clk);
            n++;
        end
        if (an_a !== want) chk("wait_an_timeout", {8'd0, an_a}, {8'd0, want});
    endtask

    task automatic load(input logic [3:0] v);
        count = v;
        count_load = 1'b1;
        @(negedge clk);
        count_load = 1'b0;
        @(negedge clk);
    endtask

    int run;

    initial begin
        #1 Clear_n = 1'b0;
        repeat (3) @(negedge clk);
        Clear_n = 1'b1;

        // 1: first active digit after release, then async reset mid-slot
        wait_an(4'b1110);
        chk("first_dig0", {5'd0, seg_a}, {5'd0, 7'b1000000});
        repeat (3) @(negedge clk);
        #2 Clear_n = 1'b0;
        #1 chk("async_reset", {seg_a, an_a, dp_a}, {7'h7F, 4'hF, 1'b1});
        @(negedge clk);
        Clear_n = 1'b1;

        // 2: value 12
        load(4'd12);
        wait_an(4'b1110); chk("v12_dig0", {5'd0, seg_a}, {5'd0, 7'b0100100});
        wait_an(4'b1101); chk("v12_dig1", {5'd0, seg_a}, {5'd0, 7'b1111001});
        wait_an(4'b1011); chk("v12_dig2", {5'd0, seg_a}, {5'd0, 7'h7F});
        wait_an(4'b0111); chk("v12_dig3", {4'd0, seg_a, dp_a}, {4'd0, 7'b1000000, 1'b0});

        // 3: value 5, leading zero handling, ignored count change
        load(4'd5);
        wait_an(4'b1101);
        chk("v5_dig1_lz", {5'd0, seg_a}, {5'd0, 7'h7F});
        chk("v5_dig1_nlz", {5'd0, seg_b}, {5'd0, 7'b1000000});
        count = 4'd9;
        wait_an(4'b1110); chk("v5_ignore9", {5'd0, seg_a}, {5'd0, 7'b0010010});

        // 4: wrap counting
        load(4'd15); load(4'd0);
        wait_an(4'b0111); chk("wrap_1", {5'd0, seg_a}, {5'd0, 7'b1111001});
        load(4'd15); load(4'd15); load(4'd3); load(4'd0);
        wait_an(4'b0111); chk("wrap_hold", {5'd0, seg_a}, {5'd0, 7'b1111001});
        for (int i = 0; i < 15; i++) begin load(4'd15); load(4'd0); end
        wait_an(4'b0111); chk("wrap_16", {5'd0, seg_a}, {5'd0, 7'b1000000});

        // 5: active window length and blank gap
        wait_an(4'b1101);
        wait_an(4'b1110);
        run = 1;
        @(negedge clk);
        while (an_a === 4'b1110 && run < 40) begin run++; @(negedge clk); end
        chk("active_len", 12'(run), 12'd6);
        run = 0;
        while (an_a === 4'b1111 && run < 40) begin run++; @(negedge clk); end
        chk("blank_len", 12'(run), 12'd2);

        // 6: load coinciding with the slot 0->1 change, then reset during it
        run = 0;
        while (!((m_n % R) == R - 1 && ((m_n / R) % 4) == 0) && run < 100) begin @(negedge clk); run++; end
        load(4'd7);
        wait_an(4'b1101); chk("edge_dig1", {5'd0, seg_a}, {5'd0, 7'h7F});
        wait_an(4'b1110); chk("edge_dig0", {5'd0, seg_a}, {5'd0, 7'b1111000});
        #2 Clear_n = 1'b0;
        #1 chk("reset_active", {seg_a, an_a, dp_a}, {7'h7F, 4'hF, 1'b1});
        @(negedge clk);
        Clear_n = 1'b1;

        // randomized traffic, biased towards 15 and 0 to exercise wraps
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 2) == 0) count = ($urandom_range(0, 1) == 0) ? 4'd15 : 4'd0;
            else count = 4'($urandom);
            count_load = ($urandom_range(0, 2) == 0);
            if (i == 700) begin
                #2 Clear_n = 1'b0;
                #1 Clear_n = 1'b1;
            end
        end
        count_load = 1'b0;
        repeat (4) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

endmodule
